mem_access_unit: RTL and testbench

Parametrised successor of the MEM-stage store-alignment logic: owns the full load/store transaction between the MEM pipeline stage and an SRAM-like data bus. It computes byte strobes and lane-shifted write data, sign/zero-extends load data, raises address-error exceptions, and runs a request/response state machine that stalls the pipeline until the bus completes. It supports 32- or 64-bit data paths and flush of in-flight accesses.

---
 rtl/mem_access_unit.sv | 186 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: aligns stores onto byte lanes, extends loads, flags
// address errors and sequences one request/response transaction on an SRAM-like bus.
module mem_access_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_valid,
    input  logic                mem_write,
    input  logic [2:0]          mem_type,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   store_data,
    input  logic [2:0]          exception_in,
    input  logic [31:0]         pc_in,
    input  logic                flush,
    output logic                stall,
    output logic                load_valid,
    output logic [DATA_W-1:0]   load_data,
    output logic [1:0]          exc_code,
    output logic [ADDR_W-1:0]   bad_vaddr,
    output logic                bus_req,
    output logic                bus_wr,
    output logic [1:0]          bus_size,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W/8-1:0] bus_wstrb,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_addr_ok,
    input  logic                bus_data_ok,
    input  logic [DATA_W-1:0]   bus_rdata
);
    localparam int NB = DATA_W / 8;
    localparam int OB = $clog2(NB);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;

    state_e              state_q, state_d;
    logic [2:0]          type_q, type_d;
    logic                write_q, write_d;
    logic [OB-1:0]       off_q, off_d;
    logic                discard_q, discard_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [NB-1:0]       strb_q, strb_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic                suppressed, aligned;
    logic [OB-1:0]       req_off;
    logic [NB-1:0]       size_mask, req_strb;
    logic [DATA_W-1:0]   lane_data, req_wdata;
    logic [DATA_W-1:0]   rd_shifted, ld_ext;
    logic                ld_sign;
    int                  ld_bits;
    logic                unused_pc;

    // Only the PC's word-alignment bits matter here.
    assign unused_pc  = ^pc_in[31:2];
    assign suppressed = (exception_in != 3'b000) || (pc_in[1:0] != 2'b00);

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        req_off   = mem_addr[OB-1:0];
        size_mask = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < (1 << mem_type[1:0])) size_mask[i] = 1'b1;
        end
        lane_data = '0;
        for (int i = 0; i < NB; i++) begin
            lane_data[8*i +: 8] = size_mask[i] ? store_data[8*i +: 8] : 8'h00;
        end
        req_strb  = size_mask << req_off;
        req_wdata = lane_data << {req_off, 3'b000};
        case (mem_type[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = (mem_addr[0] == 1'b0);
            2'b10:   aligned = (mem_addr[1:0] == 2'b00);
            default: aligned = (DATA_W == 64) && (mem_addr[2:0] == 3'b000);
        endcase
    end

    // Load extraction works from the captured offset/size, not the live MEM-stage inputs.
    always_comb begin
        rd_shifted = bus_rdata >> {off_q, 3'b000};
        ld_bits    = 8 << type_q[1:0];
        if (ld_bits > DATA_W) ld_bits = DATA_W;
        ld_sign = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i == ld_bits - 1) ld_sign = rd_shifted[i];
        end
        for (int i = 0; i < DATA_W; i++) begin
            ld_ext[i] = (i < ld_bits) ? rd_shifted[i] : (ld_sign & ~type_q[2]);
        end
    end

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        write_d    = write_q;
        off_d      = off_q;
        discard_d  = discard_q;
        addr_d     = addr_q;
        strb_d     = strb_q;
        wdata_d    = wdata_q;
        stall      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        exc_code   = 2'b00;
        bad_vaddr  = '0;
        case (state_q)
            S_IDLE: begin
                discard_d = 1'b0;
                if (mem_valid && !suppressed && !flush) begin
                    if (aligned) begin
                        stall   = 1'b1;
                        state_d = S_ADDR;
                        type_d  = mem_type;
                        write_d = mem_write;
                        off_d   = req_off;
                        addr_d  = {mem_addr[ADDR_W-1:OB], {OB{1'b0}}};
                        strb_d  = mem_write ? req_strb : '0;
                        wdata_d = mem_write ? req_wdata : '0;
                    end else begin
                        exc_code  = mem_write ? 2'b10 : 2'b01;
                        bad_vaddr = mem_addr;
                    end
                end
            end
            S_ADDR: begin
                stall = 1'b1;
                if (flush) discard_d = 1'b1;
                if (bus_addr_ok) state_d = S_DATA;
            end
            S_DATA: begin
                if (flush) discard_d = 1'b1;
                if (bus_data_ok) begin
                    // A flushed transaction still completes on the bus; only its result is dropped.
                    if (!write_q && !discard_q && !flush) begin
                        load_valid = 1'b1;
                        load_data  = ld_ext;
                    end
                    state_d   = S_IDLE;
                    discard_d = 1'b0;
                    type_d    = '0;
                    write_d   = 1'b0;
                    off_d     = '0;
                    addr_d    = '0;
                    strb_d    = '0;
                    wdata_d   = '0;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            type_q    <= '0;
            write_q   <= 1'b0;
            off_q     <= '0;
            discard_q <= 1'b0;
            addr_q    <= '0;
            strb_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            write_q   <= write_d;
            off_q     <= off_d;
            discard_q <= discard_d;
            addr_q    <= addr_d;
            strb_q    <= strb_d;
            wdata_q   <= wdata_d;
        end
    end

    assign bus_req   = (state_q == S_ADDR);
    assign bus_wr    = write_q;
    assign bus_size  = type_q[1:0];
    assign bus_addr  = addr_q;
    assign bus_wstrb = strb_q;
    assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, multi-cycle corner
// sequences and randomized ops scored against a transaction-level reference model.
module tb_mem_access_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        mv32, mv64, mem_write, flush, aok, dok;
    logic [2:0]  mem_type, exc_in;
    logic [31:0] mem_addr, pc;
    logic [63:0] sd, rd;

    logic        s32_stall, s32_lv, s32_req, s32_wr;
    logic [31:0] s32_ld, s32_badv, s32_baddr, s32_wdata;
    logic [1:0]  s32_exc, s32_size;
    logic [3:0]  s32_strb;

    logic        s64_stall, s64_lv, s64_req, s64_wr;
    logic [63:0] s64_ld, s64_wdata;
    logic [31:0] s64_badv, s64_baddr;
    logic [1:0]  s64_exc, s64_size;
    logic [7:0]  s64_strb;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32)) dut32 (
        .clk(clk), .rst(rst), .mem_valid(mv32), .mem_write(mem_write), .mem_type(mem_type),
        .mem_addr(mem_addr), .store_data(sd[31:0]), .exception_in(exc_in), .pc_in(pc),
        .flush(flush), .stall(s32_stall), .load_valid(s32_lv), .load_data(s32_ld),
        .exc_code(s32_exc), .bad_vaddr(s32_badv), .bus_req(s32_req), .bus_wr(s32_wr),
        .bus_size(s32_size), .bus_addr(s32_baddr), .bus_wstrb(s32_strb), .bus_wdata(s32_wdata),
        .bus_addr_ok(aok), .bus_data_ok(dok), .bus_rdata(rd[31:0])
    );

    mem_access_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (
        .clk(clk), .rst(rst), .mem_valid(mv64), .mem_write(mem_write), .mem_type(mem_type),
        .mem_addr(mem_addr), .store_data(sd), .exception_in(exc_in), .pc_in(pc),
        .flush(flush), .stall(s64_stall), .load_valid(s64_lv), .load_data(s64_ld),
        .exc_code(s64_exc), .bad_vaddr(s64_badv), .bus_req(s64_req), .bus_wr(s64_wr),
        .bus_size(s64_size), .bus_addr(s64_baddr), .bus_wstrb(s64_strb), .bus_wdata(s64_wdata),
        .bus_addr_ok(aok), .bus_data_ok(dok), .bus_rdata(rd)
    );

    // Observation mux: the task under way looks at whichever instance it is driving.
    logic        sel64;
    logic        o_stall, o_lv, o_req, o_wr;
    logic [1:0]  o_exc, o_size;
    logic [31:0] o_badv, o_baddr;
    logic [7:0]  o_strb;
    logic [63:0] o_wdata, o_ld;

    always_comb begin
        if (sel64) begin
            o_stall = s64_stall; o_lv = s64_lv; o_req = s64_req; o_wr = s64_wr;
            o_exc = s64_exc; o_size = s64_size; o_badv = s64_badv; o_baddr = s64_baddr;
            o_strb = s64_strb; o_wdata = s64_wdata; o_ld = s64_ld;
        end else begin
            o_stall = s32_stall; o_lv = s32_lv; o_req = s32_req; o_wr = s32_wr;
            o_exc = s32_exc; o_size = s32_size; o_badv = s32_badv; o_baddr = s32_baddr;
            o_strb = {4'h0, s32_strb}; o_wdata = {32'h0, s32_wdata}; o_ld = {32'h0, s32_ld};
        end
    end

    typedef struct {
        logic        wr;
        logic [2:0]  ty;
        logic [31:0] addr;
        logic [63:0] sd;
        logic [63:0] rd;
        logic [2:0]  ein;
        logic [31:0] pc;
        logic        issue;
        logic [1:0]  exc;
        logic [7:0]  strb;
        logic [63:0] wdata;
        logic [31:0] baddr;
        logic [63:0] ld;
        int          alat;
        int          dlat;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic wr, input logic [2:0] ty, input logic [31:0] addr,
                                input logic [63:0] sdv, input logic [63:0] rdv, input logic [2:0] ein,
                                input logic [31:0] pcv, input logic issue, input logic [1:0] exc,
                                input logic [7:0] strb, input logic [63:0] wdata,
                                input logic [31:0] baddr, input logic [63:0] ld,
                                input int alat, input int dlat);
        vec_t v;
        v.wr = wr; v.ty = ty; v.addr = addr; v.sd = sdv; v.rd = rdv; v.ein = ein; v.pc = pcv;
        v.issue = issue; v.exc = exc; v.strb = strb; v.wdata = wdata; v.baddr = baddr;
        v.ld = ld; v.alat = alat; v.dlat = dlat;
        return v;
    endfunction

    // Reference model: expected behaviour of one op from size/offset arithmetic.
    function automatic vec_t model(input bit w64, input logic wr, input logic [2:0] ty,
                                   input logic [31:0] addr, input logic [63:0] sdv,
                                   input logic [63:0] rdv, input logic [2:0] ein,
                                   input logic [31:0] pcv);
        vec_t v;
        int nb, bytes, off;
        longint unsigned m, val, dmask;
        nb    = w64 ? 8 : 4;
        dmask = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        bytes = 1 << ty[1:0];
        off   = int'(addr % nb);
        v.wr = wr; v.ty = ty; v.addr = addr; v.sd = sdv & dmask; v.rd = rdv & dmask;
        v.ein = ein; v.pc = pcv;
        v.issue = 1'b0; v.exc = 2'd0; v.strb = 8'h0; v.wdata = '0; v.ld = '0;
        v.baddr = addr - 32'(off);
        v.alat = int'($urandom_range(0, 3));
        v.dlat = int'($urandom_range(0, 3));
        if (ein == 3'b000 && pcv % 4 == 0) begin
            if (bytes > nb || addr % bytes != 0) begin
                v.exc = wr ? 2'd2 : 2'd1;
            end else begin
                v.issue = 1'b1;
                m = (bytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : (64'd1 << (8 * bytes)) - 64'd1;
                if (wr) begin
                    v.strb  = 8'(((1 << bytes) - 1) << off);
                    v.wdata = ((v.sd & m) << (8 * off)) & dmask;
                end else begin
                    val = (v.rd >> (8 * off)) & m;
                    if (!ty[2] && val[8 * bytes - 1]) val = val | ~m;
                    v.ld = val & dmask;
                end
            end
        end
        return v;
    endfunction

    // Runs one op from IDLE through to completion with the vector's bus latencies.
    task automatic run_op(input string tag, input vec_t v, input bit w64);
        sel64 = w64;
        mem_write = v.wr; mem_type = v.ty; mem_addr = v.addr; sd = v.sd;
        exc_in = v.ein; pc = v.pc; aok = 1'b0; dok = 1'b0; rd = '0;
        if (w64) mv64 = 1'b1; else mv32 = 1'b1;
        @(negedge clk);
        check({tag, ".exc"}, o_exc, v.exc);
        if (v.exc != 2'd0) check({tag, ".bad_vaddr"}, o_badv, v.addr);
        check({tag, ".issue_stall"}, o_stall, v.issue);
        @(posedge clk); #1;
        mv32 = 1'b0; mv64 = 1'b0;
        if (!v.issue) begin
            @(negedge clk);
            check({tag, ".no_req"}, o_req, 1'b0);
            check({tag, ".no_strb"}, o_strb, 8'h0);
            return;
        end
        for (int i = 0; i <= v.alat; i++) begin
            aok = (i == v.alat);
            @(negedge clk);
            check({tag, ".req"}, o_req, 1'b1);
            check({tag, ".addr_stall"}, o_stall, 1'b1);
            if (i == v.alat) begin
                check({tag, ".bus_addr"}, o_baddr, v.baddr);
                check({tag, ".wstrb"}, o_strb, v.strb);
                check({tag, ".wdata"}, o_wdata, v.wdata);
                check({tag, ".bus_wr"}, o_wr, v.wr);
                check({tag, ".bus_size"}, o_size, v.ty[1:0]);
            end
            @(posedge clk); #1;
        end
        aok = 1'b0;
        for (int i = 0; i <= v.dlat; i++) begin
            dok = (i == v.dlat);
            rd  = (i == v.dlat) ? v.rd : {$urandom, $urandom};
            @(negedge clk);
            check({tag, ".data_req"}, o_req, 1'b0);
            if (i == v.dlat) begin
                check({tag, ".done_stall"}, o_stall, 1'b0);
                check({tag, ".load_valid"}, o_lv, !v.wr);
                if (!v.wr) check({tag, ".load_data"}, o_ld, v.ld);
            end else begin
                check({tag, ".wait_stall"}, o_stall, 1'b1);
                check({tag, ".early_lv"}, o_lv, 1'b0);
            end
            @(posedge clk); #1;
        end
        dok = 1'b0;
    endtask

    vec_t        tbl32[$];
    vec_t        tbl64[$];
    vec_t        v;
    bit          rw64;
    logic        r_wr;
    logic [2:0]  r_ty, r_ein;
    logic [31:0] r_addr, r_pc;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; sel64 = 1'b0; mv32 = 1'b0; mv64 = 1'b0; mem_write = 1'b0; flush = 1'b0;
        aok = 1'b0; dok = 1'b0; mem_type = '0; exc_in = '0; mem_addr = '0; pc = 32'h100;
        sd = '0; rd = '0;

        // Directed vectors: {wr, type, addr, sd, rd, exc_in, pc, issue, exc, strb, wdata, bus_addr, load, alat, dlat}
        tbl32.push_back(mk(1, 3'b000, 32'h1003, 64'hAB, 0, 0, 32'h100, 1, 0, 8'h08, 64'hAB00_0000, 32'h1000, 0, 1, 2));
        tbl32.push_back(mk(0, 3'b001, 32'h2002, 0, 64'h8001_1234, 0, 32'h100, 1, 0, 8'h00, 0, 32'h2000, 64'hFFFF_8001, 0, 0));
        tbl32.push_back(mk(0, 3'b101, 32'h2002, 0, 64'h8001_1234, 0, 32'h100, 1, 0, 8'h00, 0, 32'h2000, 64'h0000_8001, 0, 0));
        tbl32.push_back(mk(0, 3'b010, 32'h2001, 0, 0, 0, 32'h100, 0, 2'd1, 8'h00, 0, 0, 0, 0, 0));
        tbl32.push_back(mk(1, 3'b010, 32'h2001, 64'h55, 0, 0, 32'h100, 0, 2'd2, 8'h00, 0, 0, 0, 0, 0));
        tbl32.push_back(mk(1, 3'b010, 32'h3000, 64'h77, 0, 3'b010, 32'h100, 0, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl32.push_back(mk(0, 3'b010, 32'h2000, 0, 0, 0, 32'h102, 0, 0, 8'h00, 0, 0, 0, 0, 0));
        tbl32.push_back(mk(1, 3'b011, 32'h2000, 64'h1, 0, 0, 32'h100, 0, 2'd2, 8'h00, 0, 0, 0, 0, 0));
        tbl32.push_back(mk(0, 3'b011, 32'h2000, 0, 0, 0, 32'h100, 0, 2'd1, 8'h00, 0, 0, 0, 0, 0));
        tbl32.push_back(mk(0, 3'b100, 32'h2001, 0, 64'h8001_1234, 0, 32'h100, 1, 0, 8'h00, 0, 32'h2000, 64'h12, 0, 1));
        tbl32.push_back(mk(0, 3'b000, 32'h2003, 0, 64'h8001_1234, 0, 32'h100, 1, 0, 8'h00, 0, 32'h2000, 64'hFFFF_FF80, 2, 0));
        tbl32.push_back(mk(1, 3'b001, 32'h1002, 64'h1234_CDEF, 0, 0, 32'h100, 1, 0, 8'h0C, 64'hCDEF_0000, 32'h1000, 0, 0, 0));
        tbl32.push_back(mk(1, 3'b010, 32'h1004, 64'hDEAD_BEEF, 0, 0, 32'h100, 1, 0, 8'h0F, 64'hDEAD_BEEF, 32'h1004, 0, 3, 0));
        tbl32.push_back(mk(0, 3'b010, 32'h2000, 0, 64'h8001_1234, 0, 32'h100, 1, 0, 8'h00, 0, 32'h2000, 64'h8001_1234, 0, 3));

        tbl64.push_back(mk(0, 3'b010, 32'h4004, 0, 64'hF000_0000_0000_0001, 0, 32'h100, 1, 0, 8'h00, 0, 32'h4000, 64'hFFFF_FFFF_F000_0000, 0, 0));
        tbl64.push_back(mk(0, 3'b110, 32'h4004, 0, 64'hF000_0000_0000_0001, 0, 32'h100, 1, 0, 8'h00, 0, 32'h4000, 64'h0000_0000_F000_0000, 1, 1));
        tbl64.push_back(mk(1, 3'b011, 32'h4004, 64'h1, 0, 0, 32'h100, 0, 2'd2, 8'h00, 0, 0, 0, 0, 0));
        tbl64.push_back(mk(1, 3'b011, 32'h4008, 64'h0123_4567_89AB_CDEF, 0, 0, 32'h100, 1, 0, 8'hFF, 64'h0123_4567_89AB_CDEF, 32'h4008, 0, 0, 0));
        tbl64.push_back(mk(0, 3'b100, 32'h4007, 0, 64'hF000_0000_0000_0001, 0, 32'h100, 1, 0, 8'h00, 0, 32'h4000, 64'hF0, 0, 2));
        tbl64.push_back(mk(1, 3'b000, 32'h4007, 64'hAB, 0, 0, 32'h100, 1, 0, 8'h80, 64'hAB00_0000_0000_0000, 32'h4000, 0, 2, 0));
        tbl64.push_back(mk(0, 3'b011, 32'h4010, 0, 64'h8765_4321_0FED_CBA9, 0, 32'h100, 1, 0, 8'h00, 0, 32'h4010, 64'h8765_4321_0FED_CBA9, 0, 0));

        #2;
        for (int w = 0; w < 2; w++) begin
            sel64 = (w == 1);
            #1;
            check("reset.stall", o_stall, 1'b0);
            check("reset.bus_req", o_req, 1'b0);
            check("reset.load_valid", o_lv, 1'b0);
            check("reset.exc_code", o_exc, 2'b00);
            check("reset.wstrb", o_strb, 8'h0);
            check("reset.bus_addr", o_baddr, 32'h0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        foreach (tbl32[i]) run_op($sformatf("vec32_%0d", i), tbl32[i], 1'b0);
        foreach (tbl64[i]) run_op($sformatf("vec64_%0d", i), tbl64[i], 1'b1);

        // Flush in IDLE blocks issue and exception reporting.
        sel64 = 1'b0;
        mem_write = 1'b0; mem_type = 3'b010; mem_addr = 32'h2000; exc_in = '0; pc = 32'h100;
        mv32 = 1'b1; flush = 1'b1;
        @(negedge clk);
        check("idle_flush.stall", o_stall, 1'b0);
        check("idle_flush.exc", o_exc, 2'b00);
        @(posedge clk); #1;
        mv32 = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("idle_flush.no_req", o_req, 1'b0);
        @(posedge clk); #1;

        // Flush while waiting for addr_ok: request held, result dropped, next op waits.
        mem_write = 1'b0; mem_type = 3'b010; mem_addr = 32'h2000; mv32 = 1'b1;
        @(negedge clk);
        check("flush.issue_stall", o_stall, 1'b1);
        @(posedge clk); #1;
        mem_write = 1'b1; mem_addr = 32'h1000; sd = 64'h1122_3344; flush = 1'b1;
        @(negedge clk);
        check("flush.req", o_req, 1'b1);
        check("flush.stall", o_stall, 1'b1);
        check("flush.exc", o_exc, 2'b00);
        @(posedge clk); #1;
        flush = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("flush.req_held", o_req, 1'b1);
            check("flush.addr_stable", o_baddr, 32'h2000);
            check("flush.wr_stable", o_wr, 1'b0);
            check("flush.stall_held", o_stall, 1'b1);
            @(posedge clk); #1;
        end
        aok = 1'b1;
        @(negedge clk);
        check("flush.req_at_ok", o_req, 1'b1);
        @(posedge clk); #1;
        aok = 1'b0; dok = 1'b1; rd = 64'h1234_5678;
        @(negedge clk);
        check("flush.dropped_lv", o_lv, 1'b0);
        check("flush.done_stall", o_stall, 1'b0);
        check("flush.data_req", o_req, 1'b0);
        @(posedge clk); #1;
        dok = 1'b0;
        @(negedge clk);
        check("flush.next_issue", o_stall, 1'b1);
        @(posedge clk); #1;
        mv32 = 1'b0; aok = 1'b1;
        @(negedge clk);
        check("flush.next_req", o_req, 1'b1);
        check("flush.next_wstrb", o_strb, 8'h0F);
        check("flush.next_wdata", o_wdata, 64'h1122_3344);
        check("flush.next_wr", o_wr, 1'b1);
        @(posedge clk); #1;
        aok = 1'b0; dok = 1'b1;
        @(negedge clk);
        check("flush.next_done", o_stall, 1'b0);
        check("flush.next_lv", o_lv, 1'b0);
        @(posedge clk); #1;
        dok = 1'b0;

        // addr_ok and data_ok together in ADDR: only addr_ok counts.
        mem_write = 1'b0; mem_type = 3'b010; mem_addr = 32'h2004; mv32 = 1'b1;
        @(posedge clk); #1;
        mv32 = 1'b0; aok = 1'b1; dok = 1'b1; rd = 64'hCAFE_F00D;
        @(negedge clk);
        check("both_ok.req", o_req, 1'b1);
        check("both_ok.stall", o_stall, 1'b1);
        check("both_ok.lv", o_lv, 1'b0);
        @(posedge clk); #1;
        aok = 1'b0; dok = 1'b0;
        @(negedge clk);
        check("both_ok.data_stall", o_stall, 1'b1);
        check("both_ok.data_lv", o_lv, 1'b0);
        @(posedge clk); #1;
        dok = 1'b1;
        @(negedge clk);
        check("both_ok.final_lv", o_lv, 1'b1);
        check("both_ok.final_ld", o_ld, 64'hCAFE_F00D);
        check("both_ok.final_stall", o_stall, 1'b0);
        @(posedge clk); #1;
        dok = 1'b0;

        // Asynchronous reset while a request is outstanding.
        mem_write = 1'b0; mem_type = 3'b010; mem_addr = 32'h2008; mv32 = 1'b1;
        @(posedge clk); #1;
        mv32 = 1'b0;
        @(negedge clk);
        check("async_rst.req_before", o_req, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst.req_drop", o_req, 1'b0);
        check("async_rst.stall_drop", o_stall, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("async_rst.idle_after", o_req, 1'b0);
        @(posedge clk); #1;

        // Randomized ops against the reference model.
        for (int k = 0; k < 60; k++) begin
            rw64   = (k >= 40);
            r_wr   = 1'($urandom_range(0, 1));
            r_ty   = 3'($urandom_range(0, 7));
            r_addr = 32'h5000 | 32'($urandom_range(0, 15));
            r_ein  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            r_pc   = ($urandom_range(0, 7) == 0) ? (32'h100 | 32'($urandom_range(1, 3))) : 32'h100;
            v = model(rw64, r_wr, r_ty, r_addr, {$urandom, $urandom}, {$urandom, $urandom}, r_ein, r_pc);
            run_op($sformatf("rnd%0d", k), v, rw64);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
